// File: rtl/mask_frame_streamer_if.sv
// Pixel-stream bus between the mask frame buffer, the streamer and the centroid stage.
// ADDR_W must match the streamer's derived address width.
interface mask_frame_streamer_if #(
  parameter int unsigned ADDR_W = 20
);
  logic              start_in;
  logic [ADDR_W-1:0] addr_out;
  logic              mask_in;
  logic [10:0]       x_out;
  logic [9:0]        y_out;
  logic              valid_out;
  logic              tabulate_out;
  logic [31:0]       mass_out;
  logic              busy_out;

  modport slave (
    input  start_in, mask_in,
    output addr_out, x_out, y_out, valid_out, tabulate_out, mass_out, busy_out
  );

  modport master (
    output start_in, mask_in,
    input  addr_out, x_out, y_out, valid_out, tabulate_out, mass_out, busy_out
  );
endinterface

// File: rtl/mask_frame_streamer.sv
// Raster-scans a 1-bit mask BRAM, emitting (x,y) beats for set pixels and an end-of-frame tabulate.
// Optional MASK_STREAMER_SUBSAMPLE_EN: only even/even pixels are eligible for beats.
module mask_frame_streamer #(
  parameter int unsigned H_ACTIVE   = 1280,
  parameter int unsigned V_ACTIVE   = 720,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  mask_frame_streamer_if.slave  bus
);
  localparam int unsigned       ADDR_W     = $clog2(H_ACTIVE*V_ACTIVE);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(H_ACTIVE*V_ACTIVE-1);
  localparam logic [10:0]       LAST_X     = 11'(H_ACTIVE-1);
  localparam logic [2:0]        DRAIN_LAST = 3'(RD_LATENCY);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, TAB} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [10:0]       sx_q, sx_d;
  logic [9:0]        sy_q, sy_d;
  logic [2:0]        drn_q, drn_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [31:0]       mass_q, mass_d;
  logic              valid_q, valid_d;
  logic [10:0]       x_q, x_d;
  logic [9:0]        y_q, y_d;
  logic              tab_q, tab_d;
  logic              busy_q, busy_d;
  logic              scan_v;

  // Coordinate/eligibility delay line, aligned with the BRAM read latency
  logic              pv_q [RD_LATENCY];
  logic [10:0]       px_q [RD_LATENCY];
  logic [9:0]        py_q [RD_LATENCY];

`ifdef MASK_STREAMER_SUBSAMPLE_EN
  assign scan_v = (state_q == SCAN) && !sx_q[0] && !sy_q[0];
`else
  assign scan_v = (state_q == SCAN);
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    drn_d   = drn_q;
    cnt_d   = cnt_q;
    mass_d  = mass_q;
    valid_d = pv_q[RD_LATENCY-1] & bus.mask_in;
    x_d     = valid_d ? px_q[RD_LATENCY-1] : '0;
    y_d     = valid_d ? py_q[RD_LATENCY-1] : '0;
    if (valid_d && (cnt_q != '1)) cnt_d = cnt_q + 32'd1;

    case (state_q)
      IDLE: begin
        if (bus.start_in) begin
          state_d = SCAN;
          addr_d  = '0;
          sx_d    = '0;
          sy_d    = '0;
          cnt_d   = '0;
        end
      end
      SCAN: begin
        if (addr_q == LAST_ADDR) begin
          state_d = DRAIN;
          drn_d   = '0;
        end else begin
          addr_d = addr_q + 1'b1;
          if (sx_q == LAST_X) begin
            sx_d = '0;
            sy_d = sy_q + 10'd1;
          end else begin
            sx_d = sx_q + 11'd1;
          end
        end
      end
      DRAIN: begin
        // Count includes the final beat, which lands in the last DRAIN cycle
        if (drn_q == DRAIN_LAST) begin
          state_d = TAB;
          mass_d  = cnt_q;
        end else begin
          drn_d = drn_q + 3'd1;
        end
      end
      TAB:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    tab_d  = (state_d == TAB);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      addr_q  <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      drn_q   <= '0;
      cnt_q   <= '0;
      mass_q  <= '0;
      valid_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      tab_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      drn_q   <= drn_d;
      cnt_q   <= cnt_d;
      mass_q  <= mass_d;
      valid_q <= valid_d;
      x_q     <= x_d;
      y_q     <= y_d;
      tab_q   <= tab_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < RD_LATENCY; i++) begin
        pv_q[i] <= 1'b0;
        px_q[i] <= '0;
        py_q[i] <= '0;
      end
    end else begin
      pv_q[0] <= scan_v;
      px_q[0] <= sx_q;
      py_q[0] <= sy_q;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        pv_q[i] <= pv_q[i-1];
        px_q[i] <= px_q[i-1];
        py_q[i] <= py_q[i-1];
      end
    end
  end

  assign bus.addr_out     = addr_q;
  assign bus.x_out        = x_q;
  assign bus.y_out        = y_q;
  assign bus.valid_out    = valid_q;
  assign bus.tabulate_out = tab_q;
  assign bus.mass_out     = mass_q;
  assign bus.busy_out     = busy_q;
endmodule

// File: doc/mask_frame_streamer.md
Name: mask_frame_streamer

Overview:
- Producer side of the pixel-coordinate/tabulate interface consumed by the centroid stage.
- On each start pulse, raster-scans a 1-bit detection mask held in an external BRAM.
- Emits one (x, y, valid) beat per mask pixel that is set, then a single end-of-frame tabulate pulse.
- Sits between the threshold/mask frame buffer and the centroid computation.

Parameters:
- H_ACTIVE, 1280: pixels per line scanned.
- V_ACTIVE, 720: lines per frame scanned.
- RD_LATENCY, 2: BRAM read latency in cycles, range 1..4.
- Derived (localparam): ADDR_W = $clog2(H_ACTIVE*V_ACTIVE).

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous, active-high reset.
- start_in  input  1  one-cycle pulse that begins a frame scan; ignored while busy_out=1.
- addr_out  output  ADDR_W  mask BRAM read address, equal to y*H_ACTIVE + x.
- mask_in  input  1  BRAM read data; valid RD_LATENCY cycles after the address is driven.
- x_out  output  11  pixel column of the current beat.
- y_out  output  10  pixel row of the current beat.
- valid_out  output  1  high for one cycle per set mask pixel.
- tabulate_out  output  1  one-cycle end-of-frame pulse.
- mass_out  output  32  count of valid_out beats in the last completed frame.
- busy_out  output  1  high while a scan is in progress.

Behaviour:
- Reset values: addr_out, x_out, y_out, valid_out, tabulate_out, mass_out and busy_out are all 0. State = IDLE.
- States: IDLE -> SCAN -> DRAIN -> TAB -> IDLE.
- IDLE:
  - start_in=1 at cycle 0 -> SCAN at cycle 1, addr_out=0, busy_out=1.
  - The frame-local beat counter clears.
- SCAN:
  - addr_out increments by 1 each cycle.
  - Internal scan x counts 0..H_ACTIVE-1; on wrap, x returns to 0 and y increments.
  - Last address (H_ACTIVE*V_ACTIVE-1) is driven in cycle N = H_ACTIVE*V_ACTIVE; next state is DRAIN.
  - addr_out holds its last value after SCAN ends.
- Pipeline:
  - Scan x, y and a scan-valid bit go through a RD_LATENCY-deep delay line aligned with mask_in.
  - The pixel addressed in cycle t drives registered outputs in cycle t+RD_LATENCY+1.
  - In that cycle: valid_out = aligned scan-valid AND mask_in.
  - x_out/y_out carry the aligned coordinates when valid_out=1 and are 0 otherwise.
  - Total latency from address to beat is RD_LATENCY+1.
- DRAIN: lasts exactly RD_LATENCY+1 cycles so the last beat can emerge (cycle N+RD_LATENCY+1). No new addresses are issued.
- TAB:
  - In cycle N+RD_LATENCY+2: tabulate_out=1 for exactly one cycle, and mass_out loads the frame beat count.
  - The frame beat count includes a beat that occurs in the cycle just before TAB.
  - busy_out stays 1 through the TAB cycle, then drops to 0 in IDLE.
  - valid_out and tabulate_out are never high in the same cycle.
- start_in while busy_out=1: ignored; no restart, no queueing.
- start_in in the same cycle as rst_in: reset wins.
- start_in in the cycle after TAB is accepted normally, so back-to-back frames are supported.
- rst_in mid-frame:
  - Next cycle, all outputs return to reset values and no tabulate_out is emitted.
  - In-flight pipeline beats are discarded and mass_out is cleared.
- Beat counter: 32-bit saturating; it cannot wrap at legal frame sizes.
- mass_out holds its value until the next TAB or reset.

Optional Feature:
- Macro: MASK_STREAMER_SUBSAMPLE_EN.
- When defined:
  - Only pixels with x and y both even get scan-valid=1.
  - All addresses are still read and the timing is unchanged.
  - Odd pixels never produce valid_out, and mass_out counts only even/even hits.
- When undefined: every pixel is eligible, as described above.

Test Plan:
- H_ACTIVE=4, V_ACTIVE=2, RD_LATENCY=2, mask all ones, start at cycle 0 -> addr_out 0..7 in cycles 1..8. valid_out high in cycles 4..11 with (x,y) = (0,0),(1,0),(2,0),(3,0),(0,1),(1,1),(2,1),(3,1). tabulate_out in cycle 12, mass_out=8, busy_out=0 from cycle 13.
- Same size, mask set only at address 5 -> exactly one beat, (1,1) in cycle 9. tabulate_out in cycle 12, mass_out=1. All-zero mask -> no beats, tabulate_out in cycle 12, mass_out=0.
- start_in repeated at cycles 3 and 12 during a frame -> both ignored, single tabulate_out at 12. Then start at cycle 13 -> second frame, tabulate_out at cycle 25.
- rst_in asserted at cycle 6 mid-scan -> cycle 7 has all outputs 0 and state IDLE. No tabulate_out appears in the following 20 cycles.
- RD_LATENCY=1 and RD_LATENCY=4 with mask all ones -> first beat in cycle 3 / cycle 6 respectively, tabulate_out in cycle 11 / cycle 14.
- MASK_STREAMER_SUBSAMPLE_EN defined, 4x2 all-ones mask -> beats (0,0),(2,0) only, in cycles 4 and 6. tabulate_out in cycle 12, mass_out=2.
